// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// The pick function is written for a fixed maximum width so any N up to ARB_MAX_N can use it.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_N   = 64;
  localparam int unsigned ARB_IDX_W   = $clog2(ARB_MAX_N);

  // One-hot winner: first set bit of req at or above ptr, wrapping n-1 -> 0.
  function automatic logic [ARB_MAX_N-1:0] rr_pick(
    input logic [ARB_MAX_N-1:0] req,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [ARB_MAX_N-1:0] win;
    logic                 found;
    int unsigned          sum;
    logic [ARB_IDX_W-1:0] idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      if (i < n) begin
        sum = ptr + i;
        if (sum >= n) sum = sum - n;
        idx = ARB_IDX_W'(sum);
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/encoder.sv
// One-hot to binary encoder; output forced to zero while disabled.
// Purely combinational, so the index carries the same latency as its one-hot source.
module encoder #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         en,
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx
);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    idx = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (onehot[i]) idx = idx | W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin, lock-on-grant arbiter with hold timeout.
// The owner keeps the grant until done, dropping its request, or MAX_HOLD cycles elapse.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int W        = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         gnt_valid,
  output logic         timeout
);

  localparam int HW = $clog2(MAX_HOLD);

  arb_state_e           state, state_nxt;
  logic [N-1:0]         gnt_nxt;
  logic [N-1:0]         winner;
  logic [ARB_MAX_N-1:0] pick_full;
  logic [W-1:0]         rr_ptr, rr_ptr_nxt;
  logic [W-1:0]         win_idx;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  logic                 timeout_nxt;
  logic                 any_req;
  logic                 owner_req;
  logic                 hold_expire;
  logic                 release_now;
  logic                 take_new;

  assign pick_full   = rr_pick(ARB_MAX_N'(req), 32'(rr_ptr), N);
  assign winner      = pick_full[N-1:0];
  assign any_req     = |req;
  assign owner_req   = |(req & gnt);
  assign hold_expire = (hold_cnt == HW'(MAX_HOLD - 1));
  assign release_now = done | ~owner_req | hold_expire;
  assign gnt_valid   = (state == GRANT);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (winner[i]) win_idx = win_idx | W'(i);
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    rr_ptr_nxt  = rr_ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    take_new    = 1'b0;

    if (!enable) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      hold_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) take_new = 1'b1;
        end
        GRANT: begin
          if (release_now) begin
            // A hold-limit revoke only counts as a timeout if the owner had not already let go.
            timeout_nxt = hold_expire & ~done & owner_req;
            if (any_req) begin
              take_new = 1'b1;
            end else begin
              state_nxt = IDLE;
              gnt_nxt   = '0;
              hold_nxt  = '0;
            end
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          hold_nxt  = '0;
        end
      endcase
    end

    // The search pointer moves just past the winner so it is considered last next time.
    if (take_new) begin
      state_nxt  = GRANT;
      gnt_nxt    = winner;
      hold_nxt   = '0;
      rr_ptr_nxt = (win_idx == W'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end

  encoder #(
    .N(N),
    .W(W)
  ) u_encoder (
    .en    (gnt_valid),
    .onehot(gnt),
    .idx   (gnt_id)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (N=8, MAX_HOLD=16).
// Expected values are hand-derived from the round-robin pointer at each arbitration edge.
module tb_rr_grant_arbiter;

  localparam int N        = 8;
  localparam int W        = 3;
  localparam int MAX_HOLD = 16;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         enable = 1'b1;
  logic         done   = 1'b0;
  logic [N-1:0] req    = 8'hFF;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_id;
  logic         gnt_valid;
  logic         timeout;

  int n_checks = 0;
  int n_errors = 0;

  rr_grant_arbiter #(
    .N(N),
    .W(W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [N-1:0] g, input logic [W-1:0] id,
                              input logic v, input logic to);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    logic [N-1:0] exp_g;

    // Reset with every requester active.
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 8'h00, 3'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    tick();
    expect_state("first_grant", 8'h01, 3'd0, 1'b1, 1'b0);

    // Rotation through all requesters, one grant per done pulse, no bubble.
    for (int j = 1; j <= 8; j++) begin
      exp_g = 8'h01 << (j % 8);
      done  = 1'b1;
      tick();
      done  = 1'b0;
      expect_state($sformatf("rotate%0d", j), exp_g, 3'(j % 8), 1'b1, 1'b0);
      tick();
      expect_state($sformatf("rotate%0d_hold", j), exp_g, 3'(j % 8), 1'b1, 1'b0);
    end

    // Sole requester 5: owner 0 dropped, then re-granted on each done.
    req = 8'h20;
    tick();
    expect_state("solo5", 8'h20, 3'd5, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_state($sformatf("solo5_a%0d", k), 8'h20, 3'd5, 1'b1, 1'b0);
      tick();
      expect_state($sformatf("solo5_b%0d", k), 8'h20, 3'd5, 1'b1, 1'b0);
      done = 1'b1;
      tick();
      done = 1'b0;
      expect_state($sformatf("solo5_regrant%0d", k), 8'h20, 3'd5, 1'b1, 1'b0);
    end

    // Hold timeout with requester 4 alone (pointer 6 wraps round to 4).
    req = 8'h10;
    tick();
    expect_state("hold4_start", 8'h10, 3'd4, 1'b1, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      expect_state($sformatf("hold4_c%0d", i), 8'h10, 3'd4, 1'b1, 1'b0);
    end
    tick();
    expect_state("hold4_revoke", 8'h10, 3'd4, 1'b1, 1'b1);
    for (int i = 1; i < MAX_HOLD; i++) begin
      tick();
      expect_state($sformatf("hold4_r%0d", i), 8'h10, 3'd4, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    expect_state("hold4_done_wins", 8'h10, 3'd4, 1'b1, 1'b0);
    tick();
    expect_state("hold4_after", 8'h10, 3'd4, 1'b1, 1'b0);

    // Owner 2 drops its request while 6 waits.
    req = 8'h04;
    tick();
    expect_state("own2", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h44;
    tick();
    expect_state("own2_hold", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h40;
    tick();
    expect_state("drop2_to6", 8'h40, 3'd6, 1'b1, 1'b0);

    // Enable low while granted to 3.
    req = 8'h08;
    tick();
    expect_state("own3", 8'h08, 3'd3, 1'b1, 1'b0);
    enable = 1'b0;
    tick();
    expect_state("disable1", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    expect_state("disable2", 8'h00, 3'd0, 1'b0, 1'b0);
    enable = 1'b1;
    req    = 8'h18;
    tick();
    expect_state("reenable", 8'h10, 3'd4, 1'b1, 1'b0);

    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    #1;
    expect_state("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    req   = 8'h80;
    rst_n = 1'b1;
    tick();
    expect_state("post_reset7", 8'h80, 3'd7, 1'b1, 1'b0);

    // done while idle is ignored; pointer has wrapped to 0.
    enable = 1'b0;
    tick();
    expect_state("idle_again", 8'h00, 3'd0, 1'b0, 1'b0);
    enable = 1'b1;
    req    = 8'h00;
    done   = 1'b1;
    tick();
    done   = 1'b0;
    expect_state("idle_done", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'hFF;
    tick();
    expect_state("wrap_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
